// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: phase encoding,
// lamp codes and the phase-to-lamp decode.
package traffic_pkg;

    // Phase codes as seen on the phase output.
    typedef enum logic [2:0] {
        PH_MAIN_GREEN  = 3'd0,
        PH_MAIN_YELLOW = 3'd1,
        PH_ALL_RED_A   = 3'd2,
        PH_SIDE_GREEN  = 3'd3,
        PH_SIDE_YELLOW = 3'd4,
        PH_ALL_RED_B   = 3'd5
    } phase_e;

    // One-hot lamp codes {red, yellow, green}.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Returns {main_light, side_light} for a phase; unknown codes show all red.
    function automatic logic [5:0] phase_lamps(input phase_e p);
        logic [5:0] lamps;
        case (p)
            PH_MAIN_GREEN:  lamps = {LAMP_GRN, LAMP_RED};
            PH_MAIN_YELLOW: lamps = {LAMP_YEL, LAMP_RED};
            PH_ALL_RED_A:   lamps = {LAMP_RED, LAMP_RED};
            PH_SIDE_GREEN:  lamps = {LAMP_RED, LAMP_GRN};
            PH_SIDE_YELLOW: lamps = {LAMP_RED, LAMP_YEL};
            PH_ALL_RED_B:   lamps = {LAMP_RED, LAMP_RED};
            default:        lamps = {LAMP_RED, LAMP_RED};
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_timer.sv
// Shared phase timer: counts cycles since the last phase entry, with a
// synchronous clear, optional saturation at limit-1 and a terminal-count flag.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sat,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    // Terminal count: the current phase has run its full duration.
    assign tc = (count == limit - CNT_W'(1));

    // Counter: clear on phase entry, otherwise increment unless held at limit-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (!(sat && tc)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Main/side intersection phase controller. Registers the side-road request
// vote, sequences green/yellow/all-red phases on one shared timer and applies
// the emergency override. All outputs are registered Moore outputs.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = 8,
    parameter int SIDE_GREEN = 6,
    parameter int YELLOW     = 3,
    parameter int ALL_RED    = 1,
    parameter int CNT_W      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic       emerg,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] phase,
    output logic       cycle_done
);

    localparam int MAX_DUR = (1 << CNT_W) - 1;

    if (MIN_GREEN < 1 || MIN_GREEN > MAX_DUR) begin : g_bad_min_green
        $error("MIN_GREEN out of range for CNT_W");
    end
    if (SIDE_GREEN < 1 || SIDE_GREEN > MAX_DUR) begin : g_bad_side_green
        $error("SIDE_GREEN out of range for CNT_W");
    end
    if (YELLOW < 1 || YELLOW > MAX_DUR) begin : g_bad_yellow
        $error("YELLOW out of range for CNT_W");
    end
    if (ALL_RED < 1 || ALL_RED > MAX_DUR) begin : g_bad_all_red
        $error("ALL_RED out of range for CNT_W");
    end

    phase_e           state;
    phase_e           state_nx;
    logic             req_q;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] count;
    logic             tc;
    logic             timer_clr;

    // Phase duration selected by the current phase.
    always_comb begin
        limit = CNT_W'(ALL_RED);
        case (state)
            PH_MAIN_GREEN:  limit = CNT_W'(MIN_GREEN);
            PH_MAIN_YELLOW: limit = CNT_W'(YELLOW);
            PH_ALL_RED_A:   limit = CNT_W'(ALL_RED);
            PH_SIDE_GREEN:  limit = CNT_W'(SIDE_GREEN);
            PH_SIDE_YELLOW: limit = CNT_W'(YELLOW);
            PH_ALL_RED_B:   limit = CNT_W'(ALL_RED);
            default:        limit = CNT_W'(ALL_RED);
        endcase
    end

    // Next phase: clearance phases always run out; emerg holds main green and
    // cuts side green short; illegal codes recover through all-red.
    always_comb begin
        state_nx = state;
        case (state)
            PH_MAIN_GREEN:  if (tc && req_q && !emerg) state_nx = PH_MAIN_YELLOW;
            PH_MAIN_YELLOW: if (tc) state_nx = PH_ALL_RED_A;
            PH_ALL_RED_A:   if (tc) state_nx = PH_SIDE_GREEN;
            PH_SIDE_GREEN:  if (tc || emerg) state_nx = PH_SIDE_YELLOW;
            PH_SIDE_YELLOW: if (tc) state_nx = PH_ALL_RED_B;
            PH_ALL_RED_B:   if (tc) state_nx = PH_MAIN_GREEN;
            default:        state_nx = PH_ALL_RED_B;
        endcase
    end

    assign timer_clr = (state_nx != state);

    // Saturation is harmless outside main green since every other phase leaves
    // on terminal count, so it is held on to guarantee the timer never wraps.
    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clock),
        .rst   (reset),
        .clr   (timer_clr),
        .sat   (1'b1),
        .limit (limit),
        .count (count),
        .tc    (tc)
    );

    // State, request capture and outputs decoded from the next state so the
    // lamps change on the same edge as the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= PH_MAIN_GREEN;
            req_q      <= 1'b0;
            main_light <= LAMP_GRN;
            side_light <= LAMP_RED;
            phase      <= 3'd0;
            cycle_done <= 1'b0;
        end else begin
            state                    <= state_nx;
            req_q                    <= req;
            {main_light, side_light} <= phase_lamps(state_nx);
            phase                    <= state_nx;
            cycle_done               <= (state_nx == PH_MAIN_GREEN) && (state != PH_MAIN_GREEN);
        end
    end

endmodule
